// File: rtl/mdu.sv
// MDU: multiply/divide unit holding the architectural HI/LO pair; optional accumulate ops gated by MDU_MADD_EN.
// Latency: MULT_CYCLES for multiply-class ops, DIV_CYCLES for divides; mthi/mtlo write HI/LO at the accepting edge.
// Backpressure: Busy is high while an op is in flight, and every Start seen while Busy=1 is dropped.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(MAX_N + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    mdop_e         op_q;
    logic [31:0]   a_q, b_q;

    logic          long_op, div_op;
    logic          accept_long, accept_mthi, accept_mtlo, commit;

    logic          signed_op;
    logic [63:0]   ext_a, ext_b, prod;
    logic          neg_a, neg_b;
    logic [31:0]   mag_a, mag_b, divisor, uq, ur, quot, rem;
    logic          res_wr;
    logic [31:0]   res_hi, res_lo;

    assign Busy = (state_q == ST_BUSY);

    // Classify the incoming code: which ops occupy the unit, and for how long
    always_comb begin
        long_op = 1'b0;
        div_op  = 1'b0;
        case (MdOp)
            4'd1, 4'd2: long_op = 1'b1;
            4'd3, 4'd4: begin
                long_op = 1'b1;
                div_op  = 1'b1;
            end
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: long_op = 1'b1;
`endif
            default: ;
        endcase
    end

    // Next-state and control strobes; requests are only honoured when idle
    always_comb begin
        state_d     = state_q;
        accept_long = 1'b0;
        accept_mthi = 1'b0;
        accept_mtlo = 1'b0;
        commit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    accept_long = long_op;
                    accept_mthi = (MdOp == 4'd5);
                    accept_mtlo = (MdOp == 4'd6);
                    if (long_op) state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result datapath from the latched operands; the divider works on magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing
    always_comb begin
        signed_op = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                    (op_q == OP_MADD) || (op_q == OP_MSUB);
        ext_a     = signed_op ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b     = signed_op ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod      = ext_a * ext_b;

        neg_a     = signed_op & a_q[31];
        neg_b     = signed_op & b_q[31];
        mag_a     = neg_a ? (32'd0 - a_q) : a_q;
        mag_b     = neg_b ? (32'd0 - b_q) : b_q;
        divisor   = (b_q == 32'd0) ? 32'd1 : mag_b;
        uq        = mag_a / divisor;
        ur        = mag_a % divisor;
        quot      = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem       = neg_a ? (32'd0 - ur) : ur;

        res_wr    = 1'b0;
        res_hi    = HI;
        res_lo    = LO;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                {res_hi, res_lo} = prod;
                res_wr           = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // a zero divisor leaves HI/LO untouched
                if (b_q != 32'd0) begin
                    res_hi = rem;
                    res_lo = quot;
                    res_wr = 1'b1;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                {res_hi, res_lo} = {HI, LO} + prod;
                res_wr           = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                {res_hi, res_lo} = {HI, LO} - prod;
                res_wr           = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // State, operand latch, countdown and HI/LO update; reset beats both Start and commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state_q <= state_d;
            if (accept_long) begin
                op_q  <= mdop_e'(MdOp);
                a_q   <= A;
                b_q   <= B;
                cnt_q <= div_op ? DIV_LOAD : MULT_LOAD;
            end else if (commit) begin
                op_q  <= OP_NONE;
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (commit && res_wr) begin
                HI <= res_hi;
                LO <= res_lo;
            end
            if (accept_mthi) HI <= A;
            if (accept_mtlo) LO <= A;
        end
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, meaning busy cycles for any multiply-class op.
REQ-002 Parameter DIV_CYCLES, default 10, meaning busy cycles for any divide-class op.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  EX-stage request strobe; qualifies MdOp for one cycle.
REQ-006 MdOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu.
REQ-007 A  input  32  operand rs, the same forwarded value that feeds the ALU A port.
REQ-008 B  input  32  operand rt, the same forwarded value that feeds the ALU B port.
REQ-009 Busy  output  1  high while an op is in flight; the hazard unit stalls on Busy|Start for md-class instructions.
REQ-010 HI  output  32  architectural HI register; mfhi selects it into the EX result mux beside the ALU Result.
REQ-011 LO  output  32  architectural LO register; mflo selects it into the EX result mux beside the ALU Result.

Function
REQ-012 Start=1 with MdOp in 1..4 (or 7..10 when enabled) and Busy=0 SHALL latch A, B and MdOp at that edge T.
REQ-013 Busy SHALL be 1 from T+1 through T+N, where N=MULT_CYCLES for ops 1,2,7..10 and N=DIV_CYCLES for ops 3,4.
REQ-014 HI/LO SHALL update at edge T+N; Busy SHALL be 0 in the cycle after T+N; intermediate values SHALL never be visible on HI/LO.
REQ-015 A down-counter, loaded with N-1 at T and decremented each cycle, SHALL drive Busy; commit occurs when it reaches 0 while Busy=1.
REQ-016 mult: {HI,LO}=signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-017 div: LO=signed quotient truncated toward zero, HI=remainder carrying the dividend's sign; divu: unsigned quotient and remainder.
REQ-018 Divide with latched B=0: Busy SHALL run the full DIV_CYCLES; HI and LO SHALL stay unchanged.
REQ-019 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 mthi (5) / mtlo (6) with Start=1 and Busy=0 SHALL write A into HI / LO at that edge; Busy SHALL stay 0.
REQ-021 Start=1 while Busy=1 SHALL be ignored for every MdOp, including 5 and 6.
REQ-022 Start=1 with MdOp=0 or an undefined/disabled code SHALL cause no state change.
REQ-023 Operand changes on A/B after edge T SHALL not affect the in-flight result.
REQ-024 At the commit edge, a new Start SHALL be ignored because Busy is still 1; it is accepted on the next edge.

Reset
REQ-025 reset=1 at an edge SHALL force HI=0, LO=0, Busy=0, counter=0 and latched op=none.
REQ-026 reset asserted mid-operation SHALL abort the op with no HI/LO commit; reset has priority over Start and commit.
REQ-027 The first Start after reset deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro MDU_MADD_EN defined: ops 7..10 SHALL be accepted with MULT_CYCLES latency.
REQ-029 madd: {HI,LO} += signed A*B; maddu: unsigned form; msub: {HI,LO} -= signed A*B; msubu: unsigned form; all computed mod 2^64.
REQ-030 The accumulate base SHALL be {HI,LO} as held at commit time.
REQ-031 Macro MDU_MADD_EN undefined: codes 7..10 SHALL behave as MdOp=0, and no accumulate datapath SHALL be synthesized.

Verification
REQ-032 mult A=0xFFFFFFFF, B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-033 div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> HI/LO unchanged.
REQ-034 mthi A=0x12345678, then mult started, then Start+mtlo asserted while Busy -> mtlo ignored, HI/LO hold the product at commit.
REQ-035 div started, reset pulsed at cycle 4 -> HI=LO=0 and Busy=0 next cycle; no later commit occurs.
REQ-036 MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles; macro undefined -> no change, Busy stays 0.
